// File: rtl/apb_uart.sv
// APB slave UART with 8-bit frames, optional parity and sticky RX status.
// Define APB_UART_RX_SYNC_EN to route rxSerial through a two-flop synchronizer.
module apb_uart #(
    parameter int CLKS_PER_BIT = 870,
    parameter int BASE_ADDR    = 2000
) (
    input  logic        PCLK,
    input  logic        rst,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic        rxSerial,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        txSerial
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0] A_CFG = 32'(BASE_ADDR);
    localparam logic [31:0] A_STS = 32'(BASE_ADDR + 4);
    localparam logic [31:0] A_DAT = 32'(BASE_ADDR + 8);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP
    } uart_state_t;

    uart_state_t r_tx_state, r_rx_state;
    logic [CW-1:0] r_tx_cnt, r_rx_cnt;
    logic [2:0]    r_tx_bitn, r_rx_bitn;
    logic [7:0]    r_tx_shift, r_rx_shift, r_rx_byte;
    logic r_tx_par_en, r_tx_par_bit;
    logic r_rx_par_en, r_rx_par_even, r_rx_par_bad, r_rx_prev;
    logic r_par_en, r_par_even;
    logic r_rx_valid, r_par_err, r_frm_err, r_rx_ovr;

    logic w_acc, w_wr, w_rd, w_cfg_sel, w_sts_sel, w_dat_sel;
    logic w_tx_busy, w_rx, w_stop_tick, w_good, w_perr, w_frm;
    logic w_unused;

    assign w_acc     = PSEL & PENABLE;
    assign w_wr      = w_acc & PWRITE;
    assign w_rd      = w_acc & ~PWRITE;
    assign w_cfg_sel = (PADDR == A_CFG);
    assign w_sts_sel = (PADDR == A_STS);
    assign w_dat_sel = (PADDR == A_DAT);
    assign PREADY    = w_acc;
    assign w_tx_busy = (r_tx_state != S_IDLE);
    assign w_unused  = ^PWDATA[31:8];

`ifdef APB_UART_RX_SYNC_EN
    logic [1:0] r_sync;
    always_ff @(posedge PCLK or posedge rst) begin
        if (rst) r_sync <= 2'b11;
        else     r_sync <= {r_sync[0], rxSerial};
    end
    assign w_rx = r_sync[1];
`else
    assign w_rx = rxSerial;
`endif

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            if (w_cfg_sel)
                PRDATA = {27'b0, r_par_even, r_par_en, 3'b0};
            else if (w_sts_sel)
                PRDATA = {27'b0, w_tx_busy, r_rx_ovr, r_frm_err,
                          r_par_err, r_rx_valid};
            else if (w_dat_sel)
                PRDATA = {24'b0, r_rx_byte};
        end
    end

    always_ff @(posedge PCLK or posedge rst) begin
        if (rst) begin
            r_par_en   <= 1'b0;
            r_par_even <= 1'b0;
        end else if (w_wr && w_cfg_sel) begin
            r_par_en   <= PWDATA[3];
            r_par_even <= PWDATA[4];
        end
    end

    // Parity mode is captured per frame so CONFIG writes never split a frame
    always_ff @(posedge PCLK or posedge rst) begin
        if (rst) begin
            r_tx_state   <= S_IDLE;
            r_tx_cnt     <= '0;
            r_tx_bitn    <= '0;
            r_tx_shift   <= '0;
            r_tx_par_en  <= 1'b0;
            r_tx_par_bit <= 1'b0;
            txSerial     <= 1'b1;
        end else if (r_tx_state == S_IDLE) begin
            txSerial <= 1'b1;
            if (w_wr && w_dat_sel) begin
                r_tx_shift   <= PWDATA[7:0];
                r_tx_par_en  <= r_par_en;
                r_tx_par_bit <= r_par_even ? ^PWDATA[7:0] : ~^PWDATA[7:0];
                r_tx_cnt     <= '0;
                r_tx_state   <= S_START;
                txSerial     <= 1'b0;
            end
        end else if (r_tx_cnt != C_LAST) begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
        end else begin
            r_tx_cnt <= '0;
            case (r_tx_state)
                S_START: begin
                    r_tx_bitn  <= '0;
                    txSerial   <= r_tx_shift[0];
                    r_tx_state <= S_DATA;
                end
                S_DATA: begin
                    if (r_tx_bitn == 3'd7) begin
                        txSerial   <= r_tx_par_en ? r_tx_par_bit : 1'b1;
                        r_tx_state <= r_tx_par_en ? S_PAR : S_STOP;
                    end else begin
                        r_tx_bitn  <= r_tx_bitn + 1'b1;
                        r_tx_shift <= r_tx_shift >> 1;
                        txSerial   <= r_tx_shift[1];
                    end
                end
                S_PAR: begin
                    txSerial   <= 1'b1;
                    r_tx_state <= S_STOP;
                end
                default: begin
                    txSerial   <= 1'b1;
                    r_tx_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_stop_tick = (r_rx_state == S_STOP) && (r_rx_cnt == C_LAST);
    assign w_frm  = w_stop_tick & ~w_rx;
    assign w_perr = w_stop_tick & w_rx & r_rx_par_bad;
    assign w_good = w_stop_tick & w_rx & ~r_rx_par_bad;

    always_ff @(posedge PCLK or posedge rst) begin
        if (rst) begin
            r_rx_state    <= S_IDLE;
            r_rx_cnt      <= '0;
            r_rx_bitn     <= '0;
            r_rx_shift    <= '0;
            r_rx_par_en   <= 1'b0;
            r_rx_par_even <= 1'b0;
            r_rx_par_bad  <= 1'b0;
            r_rx_prev     <= 1'b1;
        end else begin
            r_rx_prev <= w_rx;
            case (r_rx_state)
                S_IDLE: begin
                    if (r_rx_prev && !w_rx) begin
                        r_rx_cnt      <= '0;
                        r_rx_par_en   <= r_par_en;
                        r_rx_par_even <= r_par_even;
                        r_rx_par_bad  <= 1'b0;
                        r_rx_state    <= S_START;
                    end
                end
                S_START: begin
                    if (r_rx_cnt != C_HALF) begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end else begin
                        r_rx_cnt   <= '0;
                        r_rx_bitn  <= '0;
                        r_rx_state <= w_rx ? S_IDLE : S_DATA;
                    end
                end
                default: begin
                    if (r_rx_cnt != C_LAST) begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end else begin
                        r_rx_cnt <= '0;
                        if (r_rx_state == S_DATA) begin
                            r_rx_shift <= {w_rx, r_rx_shift[7:1]};
                            r_rx_bitn  <= r_rx_bitn + 1'b1;
                            if (r_rx_bitn == 3'd7)
                                r_rx_state <= r_rx_par_en ? S_PAR : S_STOP;
                        end else if (r_rx_state == S_PAR) begin
                            r_rx_par_bad <= ^{r_rx_shift, w_rx} ^ ~r_rx_par_even;
                            r_rx_state   <= S_STOP;
                        end else begin
                            r_rx_state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Receiver events take priority over APB clears in the same cycle
    always_ff @(posedge PCLK or posedge rst) begin
        if (rst) begin
            r_rx_byte  <= '0;
            r_rx_valid <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_rx_ovr   <= 1'b0;
        end else begin
            if (w_good)
                r_rx_byte <= r_rx_shift;
            if (w_good)
                r_rx_valid <= 1'b1;
            else if ((w_wr && w_sts_sel) || (w_rd && w_dat_sel))
                r_rx_valid <= 1'b0;
            if (w_good && r_rx_valid)
                r_rx_ovr <= 1'b1;
            else if (w_wr && w_sts_sel)
                r_rx_ovr <= 1'b0;
            if (w_perr)
                r_par_err <= 1'b1;
            else if (w_wr && w_sts_sel)
                r_par_err <= 1'b0;
            if (w_frm)
                r_frm_err <= 1'b1;
            else if (w_wr && w_sts_sel)
                r_frm_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_uart.sv
// Directed self-checking bench for apb_uart: registers, TX framing,
// RX parity/framing/overrun handling and reset behaviour.
module tb_apb_uart;

    localparam int CPB = 32;
    localparam logic [31:0] CFG = 32'd2000;
    localparam logic [31:0] STS = 32'd2004;
    localparam logic [31:0] DAT = 32'd2008;

    logic        PCLK = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic        rxSerial = 1'b1;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        txSerial;

    int n_checks = 0;
    int n_errors = 0;

    apb_uart #(.CLKS_PER_BIT(CPB)) dut (
        .PCLK(PCLK), .rst(rst), .PADDR(PADDR), .PWDATA(PWDATA),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .rxSerial(rxSerial), .PRDATA(PRDATA), .PREADY(PREADY),
        .txSerial(txSerial)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input string tag, input logic [31:0] a,
                            input logic [31:0] exp);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        check({tag, "_pready"}, {31'b0, PREADY}, 32'd1);
        check(tag, PRDATA, exp);
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic uart_send(input logic [7:0] b, input logic pe,
                             input logic pb, input logic stop);
        @(negedge PCLK);
        rxSerial = 1'b0;
        repeat (CPB) @(negedge PCLK);
        for (int i = 0; i < 8; i++) begin
            rxSerial = b[i];
            repeat (CPB) @(negedge PCLK);
        end
        if (pe) begin
            rxSerial = pb;
            repeat (CPB) @(negedge PCLK);
        end
        rxSerial = stop;
        repeat (CPB) @(negedge PCLK);
        rxSerial = 1'b1;
        repeat (2 * CPB) @(negedge PCLK);
    endtask

    logic [10:0] tx_exp;
    logic [10:0] tx_mid;
    int          tx_bad [11];
    int          busy_cnt;

    initial begin
        repeat (3) @(negedge PCLK);
        check("rst_tx", {31'b0, txSerial}, 32'd1);
        check("rst_prdata_idle", PRDATA, 32'd0);
        rst = 1'b0;
        apb_read("rst_cfg", CFG, 32'h0);
        apb_read("rst_sts", STS, 32'h0);
        apb_read("rst_dat", DAT, 32'h0);

        apb_write(CFG, 32'hFFFF_FFFF);
        apb_read("cfg_mask", CFG, 32'h18);
        apb_write(CFG, 32'h18);
        apb_write(STS, 32'h0);
        apb_read("cfg_18", CFG, 32'h18);
        apb_read("sts_0", STS, 32'h0);
        apb_write(32'd2012, 32'hFF);
        apb_read("unmapped", 32'd2012, 32'h0);
        apb_read("cfg_keep", CFG, 32'h18);

        // TX frame: start, 0x02 LSB first, even parity 1, stop
        tx_exp = 11'b110_0000_0100;
        for (int i = 0; i < 11; i++) tx_bad[i] = 0;
        busy_cnt = 0;
        apb_write(DAT, 32'hBF5E_9D02);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = STS;
        for (int k = 0; k < 12 * CPB; k++) begin
            #1;
            if (PRDATA[4]) busy_cnt++;
            if (k < 11 * CPB) begin
                if (txSerial !== tx_exp[k / CPB]) tx_bad[k / CPB]++;
                if (k % CPB == CPB / 2) tx_mid[k / CPB] = txSerial;
            end
            @(negedge PCLK);
        end
        PSEL = 1'b0;
        for (int i = 0; i < 11; i++) begin
            check($sformatf("tx_bit%0d", i), {31'b0, tx_mid[i]},
                  {31'b0, tx_exp[i]});
            check($sformatf("tx_hold%0d", i), tx_bad[i], 0);
        end
        check("tx_busy_len", busy_cnt, 11 * CPB);
        check("tx_idle", {31'b0, txSerial}, 32'd1);

        apb_write(DAT, 32'h55);
        repeat (2 * CPB + 4) @(negedge PCLK);
        check("tx_mid_low", {31'b0, txSerial}, 32'd0);
        rst = 1'b1;
        #1;
        check("tx_rst_abort", {31'b0, txSerial}, 32'd1);
        @(negedge PCLK);
        rst = 1'b0;
        apb_read("abort_sts", STS, 32'h0);
        apb_read("abort_cfg", CFG, 32'h0);
        apb_write(CFG, 32'h18);

        uart_send(8'hCB, 1'b1, 1'b1, 1'b1);
        apb_read("rx_cb_sts", STS, 32'h01);
        apb_read("rx_cb_dat", DAT, 32'hCB);
        apb_read("rx_cb_clr", STS, 32'h00);

        uart_send(8'hFE, 1'b1, 1'b0, 1'b1);
        apb_read("perr_sts", STS, 32'h02);
        apb_read("perr_dat", DAT, 32'hCB);
        apb_read("perr_sts2", STS, 32'h02);
        apb_write(STS, 32'h0);
        apb_read("sts_clr", STS, 32'h0);

        uart_send(8'hCB, 1'b1, 1'b1, 1'b1);
        uart_send(8'hFE, 1'b1, 1'b0, 1'b1);
        uart_send(8'hFF, 1'b1, 1'b1, 1'b1);
        uart_send(8'hFF, 1'b1, 1'b0, 1'b1);
        uart_send(8'h4B, 1'b1, 1'b0, 1'b1);
        uart_send(8'h4F, 1'b1, 1'b1, 1'b1);
        apb_read("ovr_sts", STS, 32'h0B);
        apb_read("ovr_dat", DAT, 32'h4F);
        apb_read("ovr_sts2", STS, 32'h0A);
        apb_write(STS, 32'hFFFF_FFFF);

        uart_send(8'h12, 1'b1, 1'b0, 1'b0);
        apb_read("frm_sts", STS, 32'h04);
        apb_read("frm_dat", DAT, 32'h4F);
        apb_write(STS, 32'h0);
        apb_read("frm_clr", STS, 32'h0);

        apb_write(CFG, 32'h08);
        uart_send(8'h02, 1'b1, 1'b0, 1'b1);
        apb_read("odd_sts", STS, 32'h01);
        apb_read("odd_dat", DAT, 32'h02);

        apb_write(CFG, 32'h0);
        uart_send(8'hA5, 1'b0, 1'b0, 1'b1);
        apb_read("nopar_sts", STS, 32'h01);
        apb_read("nopar_dat", DAT, 32'hA5);

        @(negedge PCLK);
        rxSerial = 1'b0;
        repeat (3) @(negedge PCLK);
        rxSerial = 1'b1;
        repeat (2 * CPB) @(negedge PCLK);
        apb_read("glitch_sts", STS, 32'h0);
        uart_send(8'h3C, 1'b0, 1'b0, 1'b1);
        apb_read("glitch_dat", DAT, 32'h3C);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
